// File: rtl/uart_rx.sv
// UART 8N1 receiver: two-flop line synchronizer, mid-bit sampling, one-cycle result strobes.
// Define UART_RX_PARITY_EN to require an even-parity bit between data bit 7 and the stop bit.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Parity_Err
);

    localparam logic [10:0] HalfCnt = 11'((CLKS_PER_BIT - 1) / 2);
    localparam logic [10:0] LastCnt = 11'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StCleanup
    } state_e;

    state_e      state_q;
    logic [10:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shadow_q;
    logic        rx_meta_q;
    logic        rx_q;
    logic        cnt_done;

`ifdef UART_RX_PARITY_EN
    logic        par_bad_q;
`endif

    assign cnt_done = (cnt_q == LastCnt);

    // The line is asynchronous; only rx_q is ever seen by the FSM.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta_q <= 1'b1;
            rx_q      <= 1'b1;
        end else begin
            rx_meta_q <= i_Rx_Serial;
            rx_q      <= rx_meta_q;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            idx_q           <= '0;
            shadow_q        <= '0;
            o_Rx_DV         <= 1'b0;
            o_Rx_Byte       <= '0;
            o_Rx_Active     <= 1'b0;
            o_Rx_Frame_Err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q       <= 1'b0;
            o_Rx_Parity_Err <= 1'b0;
`endif
        end else begin
            o_Rx_DV         <= 1'b0;
            o_Rx_Frame_Err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_Rx_Parity_Err <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (!rx_q) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfCnt) begin
                        cnt_q <= '0;
                        if (!rx_q) begin
                            o_Rx_Active <= 1'b1;
                            state_q     <= StData;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                end
                StData: begin
                    if (cnt_done) begin
                        cnt_q           <= '0;
                        shadow_q[idx_q] <= rx_q;
                        if (idx_q == 3'd7) begin
                            idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt_done) begin
                        cnt_q     <= '0;
                        par_bad_q <= ^{shadow_q, rx_q};
                        state_q   <= StStop;
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                end
`endif
                StStop: begin
                    if (cnt_done) begin
                        cnt_q <= '0;
                        if (rx_q) begin
                            o_Rx_Byte <= shadow_q;
                            o_Rx_DV   <= 1'b1;
                        end else begin
                            o_Rx_Frame_Err <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        o_Rx_Parity_Err <= par_bad_q;
`endif
                        o_Rx_Active <= 1'b0;
                        state_q     <= StCleanup;
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                end
                StCleanup: begin
                    // A held-low (break) line parks here instead of spawning new frames.
                    if (rx_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign o_Rx_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames checked against
// an event-level model (expected strobe/activity cycles derived from frame timing).
module tb_uart_rx;

    localparam int CPB = 8;
    localparam int H   = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    localparam int KRise = 0;
    localparam int KFall = 1;
    localparam int KDv   = 2;
    localparam int KFe   = 3;
    localparam int KPe   = 4;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       dv;
    logic [7:0] rx_byte;
    logic       active;
    logic       frame_err;
    logic       parity_err;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   both_cnt = 0;
    logic act_prev = 1'b0;
    logic [7:0] last_good = 8'h00;

    ev_t act_q[$];
    ev_t exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (rx_byte),
        .o_Rx_Active    (active),
        .o_Rx_Frame_Err (frame_err),
        .o_Rx_Parity_Err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input int c, input int k, input logic [7:0] d);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.data = d;
        return e;
    endfunction

    // Observed events, stamped with the number of the posedge they follow.
    always @(negedge clk) begin
        if (active !== act_prev) act_q.push_back(mk_ev(cyc, active ? KRise : KFall, 8'h00));
        if (dv === 1'b1) act_q.push_back(mk_ev(cyc, KDv, rx_byte));
        if (frame_err === 1'b1) act_q.push_back(mk_ev(cyc, KFe, rx_byte));
        if (parity_err === 1'b1) act_q.push_back(mk_ev(cyc, KPe, 8'h00));
        if (dv === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
        act_prev <= active;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_events(input string tag);
        check($sformatf("%s.count", tag), act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check($sformatf("%s[%0d].cyc", tag, i), act_q[i].cyc, exp_q[i].cyc);
            check($sformatf("%s[%0d].kind", tag, i), act_q[i].kind, exp_q[i].kind);
            check($sformatf("%s[%0d].data", tag, i), act_q[i].data, exp_q[i].data);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    // Called on a negedge; the start bit is first seen by the next posedge (E0).
    // The line is left at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        int e0;
        int conf;
        int done;
        e0   = cyc + 1;
        conf = e0 + 3 + H;
        done = conf + (9 + P) * CPB;
        exp_q.push_back(mk_ev(conf, KRise, 8'h00));
        exp_q.push_back(mk_ev(done, KFall, 8'h00));
        if (stop) begin
            exp_q.push_back(mk_ev(done, KDv, b));
            last_good = b;
        end else begin
            exp_q.push_back(mk_ev(done, KFe, last_good));
        end
        if (P == 1 && (((^b) ^ par) == 1'b1)) exp_q.push_back(mk_ev(done, KPe, 8'h00));
        rx = 1'b0;
        idle(CPB);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            idle(CPB);
        end
        if (P == 1) begin
            rx = par;
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
    endtask

    initial begin
        logic [7:0] b;
        logic       par;
        logic       stop;
        int         e0;

        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        check("rst.dv", dv, 1'b0);
        check("rst.byte", rx_byte, 8'h00);
        check("rst.active", active, 1'b0);
        check("rst.frame_err", frame_err, 1'b0);
        check("rst.parity_err", parity_err, 1'b0);
        rst = 1'b0;
        act_q.delete();
        idle(4);

        send_frame(8'hA5, 1'b0, 1'b1);
        idle(4);
        compare_events("a5");
        check("a5.byte_held", rx_byte, 8'hA5);

        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1);
        idle(4);
        compare_events("b2b");

        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(3 * CPB);
        compare_events("glitch");
        check("glitch.active", active, 1'b0);

        send_frame(8'h3C, ^8'h3C, 1'b0);
        idle(40 * CPB);
        compare_events("break");
        rx = 1'b1;
        idle(2 * CPB);
        compare_events("break_release");
        check("break.byte_held", rx_byte, 8'h55);

        // Abort a frame with reset in the middle of data bit 4.
        b  = 8'hC6;
        e0 = cyc + 1;
        exp_q.push_back(mk_ev(e0 + 3 + H, KRise, 8'h00));
        rx = 1'b0;
        idle(CPB);
        for (int k = 0; k < 4; k++) begin
            rx = b[k];
            idle(CPB);
        end
        rx = b[4];
        idle(CPB / 2);
        check("pre_rst.active", active, 1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        exp_q.push_back(mk_ev(cyc + 1, KFall, 8'h00));
        @(negedge clk);
        check("mid_rst.dv", dv, 1'b0);
        check("mid_rst.byte", rx_byte, 8'h00);
        check("mid_rst.active", active, 1'b0);
        check("mid_rst.frame_err", frame_err, 1'b0);
        check("mid_rst.parity_err", parity_err, 1'b0);
        rst = 1'b0;
        last_good = 8'h00;
        idle(3 * CPB);
        compare_events("reset");
        send_frame(8'h81, ^8'h81, 1'b1);
        idle(4);
        compare_events("post_rst");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1);
        idle(4);
        compare_events("par_bad");
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        compare_events("par_good");
`endif

        for (int i = 0; i < 12; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            par  = (P == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_frame(b, par, stop);
            if (!stop) begin
                rx = 1'b1;
                idle(2 * CPB);
            end else begin
                idle($urandom_range(0, 2 * CPB));
            end
        end
        idle(4);
        compare_events("rand");

        check("dv_fe_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
